// File: rtl/wave_osc.sv
// Sample-rate oscillator: 24-bit phase accumulator driving saw, pulse, triangle
// or LFSR-noise shapes, with hard sync and a wrap strobe for chaining voices.
module wave_osc #(
  parameter int unsigned BITDEPTH = 14
) (
  input  logic                sample_clock,
  input  logic                rst,
  input  logic                enable,
  input  logic [23:0]         freq,
  input  logic [1:0]          wave_sel,
  input  logic [7:0]          pulse_width,
  input  logic                sync,
  output logic [BITDEPTH-1:0] out,
  output logic                wrap
);

  typedef enum logic [1:0] {
    WaveSaw   = 2'd0,
    WavePulse = 2'd1,
    WaveTri   = 2'd2,
    WaveNoise = 2'd3
  } wave_e;

  localparam logic [22:0]         LfsrSeed = 23'h7FFFFF;
  localparam logic [BITDEPTH-1:0] PosFull  = {1'b0, {(BITDEPTH-1){1'b1}}};
  localparam logic [BITDEPTH-1:0] NegFull  = {1'b1, {(BITDEPTH-1){1'b0}}};

  logic [23:0]         phase_q, phase_d;
  logic [22:0]         lfsr_q, lfsr_d;
  logic [BITDEPTH-1:0] out_q, out_d;
  logic                wrap_q, wrap_d;
  logic [24:0]         phase_sum;
  logic [BITDEPTH-1:0] tri_mag;
  logic [BITDEPTH-1:0] sample;

  assign phase_sum = {1'b0, phase_q} + {1'b0, freq};

  // Second half of the cycle folds the ramp back down.
  assign tri_mag = phase_q[23] ? ~phase_q[22 -: BITDEPTH] : phase_q[22 -: BITDEPTH];

  // Subtracting FS from an unsigned B-bit value is just an MSB flip.
  always_comb begin
    sample = NegFull;
    unique case (wave_e'(wave_sel))
      WaveSaw:   sample = {~phase_q[23], phase_q[22 -: BITDEPTH-1]};
      WavePulse: sample = (phase_q[23:16] < pulse_width) ? PosFull : NegFull;
      WaveTri:   sample = {~tri_mag[BITDEPTH-1], tri_mag[BITDEPTH-2:0]};
      WaveNoise: sample = {~lfsr_q[22], lfsr_q[21 -: BITDEPTH-1]};
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    lfsr_d  = lfsr_q;
    out_d   = out_q;
    wrap_d  = 1'b0;
    if (enable) begin
      out_d = sample;
      if (sync) begin
        phase_d = '0;
      end else begin
        phase_d = phase_sum[23:0];
        wrap_d  = phase_sum[24];
      end
      if (!phase_q[19] && phase_d[19]) begin
        lfsr_d = {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]};
      end
    end
  end

  always_ff @(posedge sample_clock or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      lfsr_q  <= LfsrSeed;
      out_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      lfsr_q  <= lfsr_d;
      out_q   <= out_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out  = out_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_wave_osc.sv
// Bench for wave_osc: directed vector table, hand sequences for the corner cases,
// and randomized stimulus checked against an arithmetic reference model.
module tb_wave_osc;

  localparam int B  = 14;
  localparam int FS = 1 << (B - 1);

  logic          sample_clock = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [23:0]   freq = '0;
  logic [1:0]    wave_sel = '0;
  logic [7:0]    pulse_width = '0;
  logic          sync = 1'b0;
  logic [B-1:0]  out;
  logic          wrap;

  wave_osc #(.BITDEPTH(B)) dut (
    .sample_clock(sample_clock),
    .rst(rst),
    .enable(enable),
    .freq(freq),
    .wave_sel(wave_sel),
    .pulse_width(pulse_width),
    .sync(sync),
    .out(out),
    .wrap(wrap)
  );

  always #5 sample_clock = ~sample_clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int m_phase;
  int m_lfsr;
  int m_out;
  bit m_wrap;

  typedef struct {
    bit en;
    int fr;
    int sel;
    int pw;
    bit sy;
    int e_out;
    bit e_wrap;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_sample(input int sel, input int pw);
    int p;
    case (sel)
      0: return (m_phase >> (24 - B)) - FS;
      1: return ((m_phase >> 16) < pw) ? FS - 1 : -FS;
      2: begin
        p = (m_phase % (1 << 23)) >> (23 - B);
        if (m_phase >= (1 << 23)) p = (1 << B) - 1 - p;
        return p - FS;
      end
      default: return (m_lfsr >> (23 - B)) - FS;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_lfsr  = 'h7FFFFF;
    m_out   = 0;
    m_wrap  = 0;
  endtask

  task automatic model_step(input bit en, input int fr, input int sel, input int pw,
                            input bit sy);
    int smp;
    int sum;
    int nxt;
    m_wrap = 0;
    if (!en) return;
    smp = model_sample(sel, pw);
    sum = m_phase + fr;
    nxt = sy ? 0 : sum % (1 << 24);
    m_wrap = !sy && (sum >= (1 << 24));
    if (((nxt >> 19) & 1) == 1 && ((m_phase >> 19) & 1) == 0)
      m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 22) ^ (m_lfsr >> 17)) & 1)) & 'h7FFFFF;
    m_phase = nxt;
    m_out = smp;
  endtask

  // Drive one sample's inputs, advance the model, then sample the DUT 1 ns after the edge.
  task automatic tick(input bit en, input int fr, input int sel, input int pw, input bit sy,
                      input bit chk, input string tag);
    enable      = en;
    freq        = fr[23:0];
    wave_sel    = sel[1:0];
    pulse_width = pw[7:0];
    sync        = sy;
    model_step(en, fr, sel, pw, sy);
    @(posedge sample_clock);
    #1;
    if (chk) begin
      check({tag, " out"}, int'($signed(out)), m_out);
      check({tag, " wrap"}, int'(wrap), int'(m_wrap));
    end
  endtask

  task automatic do_reset();
    @(negedge sample_clock);
    rst    = 1'b1;
    enable = 1'b0;
    sync   = 1'b0;
    #2;
    check("reset out", int'($signed(out)), 0);
    check("reset wrap", int'(wrap), 0);
    @(negedge sample_clock);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin : main
    int n_wrap;
    int first_wrap;
    int tri_s[64];
    int exp_v;

    vecs[0]  = '{1'b1, 'h010000, 0, 0,   1'b0, -8192, 1'b0};
    vecs[1]  = '{1'b1, 'h010000, 0, 0,   1'b0, -8128, 1'b0};
    vecs[2]  = '{1'b1, 'h100000, 1, 128, 1'b0,  8191, 1'b0};
    vecs[3]  = '{1'b1, 'h040000, 2, 128, 1'b0, -5888, 1'b0};
    vecs[4]  = '{1'b1, 'h080000, 3, 128, 1'b0,  8191, 1'b0};
    vecs[5]  = '{1'b1, 'h000000, 3, 128, 1'b0,  8191, 1'b0};
    vecs[6]  = '{1'b0, 'h000000, 0, 0,   1'b1,  8191, 1'b0};
    vecs[7]  = '{1'b1, 'h000000, 0, 0,   1'b0, -6272, 1'b0};
    vecs[8]  = '{1'b1, 'hF00000, 0, 0,   1'b0, -6272, 1'b1};
    vecs[9]  = '{1'b1, 'hF40000, 0, 0,   1'b1, -7296, 1'b0};
    vecs[10] = '{1'b1, 'h000000, 1, 0,   1'b0, -8192, 1'b0};
    vecs[11] = '{1'b1, 'hFF0000, 1, 255, 1'b0,  8191, 1'b0};
    vecs[12] = '{1'b1, 'h000000, 1, 255, 1'b0, -8192, 1'b0};
    vecs[13] = '{1'b1, 'h000000, 2, 0,   1'b0, -8065, 1'b0};

    model_reset();
    #3;
    check("power-on out", int'($signed(out)), 0);
    check("power-on wrap", int'(wrap), 0);

    // Directed vector table from reset.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      tick(vecs[i].en, vecs[i].fr, vecs[i].sel, vecs[i].pw, vecs[i].sy, 1'b0, "vec");
      check($sformatf("vec%0d out", i), int'($signed(out)), vecs[i].e_out);
      check($sformatf("vec%0d wrap", i), int'(wrap), int'(vecs[i].e_wrap));
    end

    // Saw period and wrap cadence.
    do_reset();
    n_wrap = 0;
    first_wrap = -1;
    for (int e = 1; e <= 512; e++) begin
      tick(1'b1, 'h010000, 0, 0, 1'b0, 1'b1, "saw");
      if (e == 1) check("saw edge1", int'($signed(out)), -8192);
      if (e == 2) check("saw edge2", int'($signed(out)), -8128);
      if (wrap === 1'b1) begin
        n_wrap++;
        if (first_wrap < 0) first_wrap = e;
      end
    end
    check("saw wrap count", n_wrap, 2);
    check("saw first wrap", first_wrap, 256);

    // Pulse 8 high / 8 low, then zero width.
    do_reset();
    for (int i = 0; i < 48; i++) begin
      tick(1'b1, 'h100000, 1, 128, 1'b0, 1'b1, "pulse");
      exp_v = ((i % 16) < 8) ? 8191 : -8192;
      check("pulse pattern", int'($signed(out)), exp_v);
    end
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 'h100000, 1, 0, 1'b0, 1'b1, "pulse pw0");
      check("pulse pw0", int'($signed(out)), -8192);
    end

    // Triangle landmarks over one 64-sample period.
    do_reset();
    for (int i = 0; i < 64; i++) begin
      tick(1'b1, 'h040000, 2, 0, 1'b0, 1'b1, "tri");
      tri_s[i] = int'($signed(out));
    end
    check("tri phase 0", tri_s[0], -8192);
    check("tri phase 400000", tri_s[16], 0);
    check("tri phase 7C0000", tri_s[31], 7680);
    check("tri phase 800000", tri_s[32], 8191);

    // Noise against the model for 1000 samples.
    do_reset();
    for (int i = 0; i < 1000; i++) tick(1'b1, 'h080000, 3, 0, 1'b0, 1'b1, "noise");

    // Sync coincident with overflow, then enable held low.
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 'h400000, 0, 0, 1'b0, 1'b1, "pre-sync");
    tick(1'b1, 'h400000, 0, 0, 1'b1, 1'b1, "sync");
    check("sync beats overflow wrap", int'(wrap), 0);
    tick(1'b1, 'h400000, 0, 0, 1'b0, 1'b1, "post-sync");
    check("post-sync out", int'($signed(out)), -8192);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 'h400000, 3, 0, 1'(i % 2), 1'b1, "disabled");
      check("disabled out hold", int'($signed(out)), -8192);
      check("disabled wrap low", int'(wrap), 0);
    end
    tick(1'b1, 'h400000, 0, 0, 1'b0, 1'b1, "resume");
    check("resume out", int'($signed(out)), -4096);

    // Asynchronous reset mid-run.
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, 'h010000, 0, 0, 1'b0, 1'b1, "pre-rst");
    #2;
    rst = 1'b1;
    #1;
    check("async rst out", int'($signed(out)), 0);
    check("async rst wrap", int'(wrap), 0);
    @(posedge sample_clock);
    #1;
    check("held rst out", int'($signed(out)), 0);
    @(negedge sample_clock);
    rst = 1'b0;
    model_reset();
    tick(1'b1, 'h010000, 0, 0, 1'b0, 1'b1, "post-rst");
    check("post-rst edge1", int'($signed(out)), -8192);

    // Randomized stimulus against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 9) != 0,
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 'hFFFF)) :
                                         int'($urandom & 'hFFFFFF),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
           $urandom_range(0, 19) == 0, 1'b1, "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
